// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-path definitions: FSM states, instruction field layout and defaults
// used by the fetch unit, instruction register and decoder.
package instruction_fetch_unit_pkg;

    localparam int unsigned IFU_ADDR_W      = 8;
    localparam logic [3:0]  IFU_HALT_OPCODE = 4'hF;

    localparam int unsigned OPC_HI = 7;
    localparam int unsigned OPC_LO = 4;
    localparam int unsigned ARG_HI = 3;
    localparam int unsigned ARG_LO = 0;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        PRESENT,
        HALT
    } ifu_state_e;

    function automatic logic [3:0] opcode_of(input logic [7:0] ins);
        return ins[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [3:0] operand_of(input logic [7:0] ins);
        return ins[ARG_HI:ARG_LO];
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_pc_counter.sv
// Program counter register: reset value, wrap-around increment, and a jump load
// that takes priority over the increment.
module fetch_pc_counter #(
    parameter int unsigned         ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              clb_i,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clb_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: issues one memory read per instruction, waits out the memory
// latency, then offers the captured word to the instruction register.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W      = IFU_ADDR_W,
    parameter int unsigned       MEM_LAT     = 1,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [3:0]        HALT_OPCODE = IFU_HALT_OPCODE
) (
    input  logic              clk,
    input  logic              clb,
    input  logic              run,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    input  logic [7:0]        imem_data,
    output logic [7:0]        instr,
    output logic              load_ir,
    input  logic              ir_ready,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    ifu_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] instr_q, instr_d;
    logic       pc_inc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        pc_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) state_d = REQ;
            end
            REQ: begin
                cnt_d   = 3'(MEM_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    instr_d = imem_data;
                    state_d = PRESENT;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            PRESENT: begin
                if (ir_ready) begin
                    pc_inc = 1'b1;
                    if (opcode_of(instr_q) == HALT_OPCODE) state_d = HALT;
                    else if (run)                          state_d = REQ;
                    else                                   state_d = IDLE;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: state_d = IDLE;
        endcase
        // A redirect overrides everything, including a capture due this cycle.
        if (jump) begin
            state_d = REQ;
            instr_d = instr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (clb) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            instr_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
        end
    end

    fetch_pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i      (clk),
        .clb_i      (clb),
        .inc_i      (pc_inc),
        .load_i     (jump),
        .load_val_i (jump_target),
        .pc_o       (pc)
    );

    assign imem_rd   = (state_q == REQ);
    assign imem_addr = pc;
    assign load_ir   = (state_q == PRESENT);
    assign halted    = (state_q == HALT);
    assign instr     = instr_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: an 8-bit/latency-1 instance and a
// 4-bit/latency-3 instance, each fed by a small behavioural instruction memory.
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: ADDR_W=8, MEM_LAT=1, RESET_PC=0
    logic       a_clb, a_run, a_rd, a_load, a_ready, a_jump, a_halted;
    logic [7:0] a_addr, a_data, a_instr, a_tgt, a_pc;

    // Instance B: ADDR_W=4, MEM_LAT=3, RESET_PC=4'hF
    logic       b_clb, b_run, b_rd, b_load, b_ready, b_jump, b_halted;
    logic [3:0] b_addr, b_tgt, b_pc;
    logic [7:0] b_data, b_instr;

    instruction_fetch_unit #(
        .ADDR_W(8), .MEM_LAT(1), .RESET_PC(8'h00), .HALT_OPCODE(4'hF)
    ) dut_a (
        .clk(clk), .clb(a_clb), .run(a_run), .imem_addr(a_addr), .imem_rd(a_rd),
        .imem_data(a_data), .instr(a_instr), .load_ir(a_load), .ir_ready(a_ready),
        .jump(a_jump), .jump_target(a_tgt), .pc(a_pc), .halted(a_halted)
    );

    instruction_fetch_unit #(
        .ADDR_W(4), .MEM_LAT(3), .RESET_PC(4'hF), .HALT_OPCODE(4'hF)
    ) dut_b (
        .clk(clk), .clb(b_clb), .run(b_run), .imem_addr(b_addr), .imem_rd(b_rd),
        .imem_data(b_data), .instr(b_instr), .load_ir(b_load), .ir_ready(b_ready),
        .jump(b_jump), .jump_target(b_tgt), .pc(b_pc), .halted(b_halted)
    );

    // Memories drive data only in the cycle(s) the latency dictates, zero otherwise.
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [16];
    logic [7:0] pa, pb0, pb1, pb2;

    always @(posedge clk) begin
        pa  <= a_rd ? mem_a[a_addr] : 8'h00;
        pb0 <= b_rd ? mem_b[b_addr] : 8'h00;
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign a_data = pa;
    assign b_data = pb2;

    int rd_cnt_a = 0;
    always @(posedge clk) if (a_rd) rd_cnt_a <= rd_cnt_a + 1;

    logic saw_aa = 1'b0;
    always @(negedge clk) if (a_load && a_instr == 8'hAA) saw_aa = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int rc0;

    initial begin
        for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
        for (int i = 0; i < 16; i++)  mem_b[i] = 8'h00;
        pa = 8'h00; pb0 = 8'h00; pb1 = 8'h00; pb2 = 8'h00;
        a_clb = 1'b1; a_run = 1'b0; a_ready = 1'b0; a_jump = 1'b0; a_tgt = 8'h00;
        b_clb = 1'b1; b_run = 1'b0; b_ready = 1'b0; b_jump = 1'b0; b_tgt = 4'h0;
        step(2);
        a_clb = 1'b0; b_clb = 1'b0;
        check("rst_pc",     32'(a_pc),     32'h00);
        check("rst_load",   32'(a_load),   32'h0);
        check("rst_instr",  32'(a_instr),  32'h00);
        check("rst_rd",     32'(a_rd),     32'h0);
        check("rst_halted", 32'(a_halted), 32'h0);
        check("rst_pc_b",   32'(b_pc),     32'hF);

        // Straight-line fetch
        mem_a[0] = 8'h12; mem_a[1] = 8'h34; mem_a[2] = 8'h56;
        a_run = 1'b1; a_ready = 1'b1;
        step(1);
        check("sl_rd",    32'(a_rd),    32'h1);
        check("sl_addr0", 32'(a_addr),  32'h00);
        step(2);
        check("sl_load0", 32'(a_load),  32'h1);
        check("sl_ins0",  32'(a_instr), 32'h12);
        step(3);
        check("sl_load1", 32'(a_load),  32'h1);
        check("sl_ins1",  32'(a_instr), 32'h34);
        check("sl_pc1",   32'(a_pc),    32'h01);

        // Stall with ir_ready low
        a_ready = 1'b0;
        rc0 = rd_cnt_a;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("st_ins",  32'(a_instr), 32'h34);
            check("st_load", 32'(a_load),  32'h1);
            check("st_pc",   32'(a_pc),    32'h01);
        end
        check("st_nord", 32'(rd_cnt_a), 32'(rc0));
        a_ready = 1'b1;
        step(1);
        check("st_pc2",  32'(a_pc),  32'h02);
        check("st_rd2",  32'(a_rd),  32'h1);
        step(2);
        check("sl_ins2", 32'(a_instr), 32'h56);
        a_run = 1'b0;
        step(1);
        check("sl_pc3",   32'(a_pc),   32'h03);
        check("sl_idle",  32'(a_load), 32'h0);
        step(1);
        check("idle_nord", 32'(a_rd),  32'h0);

        // Jump during WAIT
        mem_a[5] = 8'hAA; mem_a[8'h40] = 8'h77;
        a_jump = 1'b1; a_tgt = 8'h05; a_run = 1'b1;
        step(1);
        check("jw_addr5", 32'(a_addr), 32'h05);
        a_jump = 1'b0;
        step(1);
        a_jump = 1'b1; a_tgt = 8'h40;
        step(1);
        check("jw_pc40",   32'(a_pc),   32'h40);
        check("jw_addr40", 32'(a_addr), 32'h40);
        check("jw_rd",     32'(a_rd),   32'h1);
        check("jw_load0",  32'(a_load), 32'h0);
        a_jump = 1'b0;
        step(2);
        check("jw_load",  32'(a_load),  32'h1);
        check("jw_ins",   32'(a_instr), 32'h77);
        a_run = 1'b0;
        step(1);
        check("jw_pc41",  32'(a_pc),    32'h41);
        check("jw_no_aa", 32'(saw_aa),  32'h0);

        // Halt and resume by jump
        mem_a[2] = 8'hF0; mem_a[8'h10] = 8'h55; mem_a[8'h20] = 8'h99;
        a_jump = 1'b1; a_tgt = 8'h02; a_run = 1'b1;
        step(1);
        a_jump = 1'b0;
        step(2);
        check("h_ins", 32'(a_instr), 32'hF0);
        step(1);
        check("h_halted", 32'(a_halted), 32'h1);
        check("h_pc3",    32'(a_pc),     32'h03);
        check("h_load",   32'(a_load),   32'h0);
        rc0 = rd_cnt_a;
        step(3);
        check("h_nord",   32'(rd_cnt_a), 32'(rc0));
        check("h_stay",   32'(a_halted), 32'h1);
        a_jump = 1'b1; a_tgt = 8'h10;
        step(1);
        check("h_clear",  32'(a_halted), 32'h0);
        check("h_pc10",   32'(a_pc),     32'h10);
        check("h_rd",     32'(a_rd),     32'h1);
        a_jump = 1'b0;
        step(2);
        check("h_ins55",  32'(a_instr),  32'h55);

        // Jump coinciding with accept: target wins over increment
        a_jump = 1'b1; a_tgt = 8'h20;
        step(1);
        check("ja_pc20",  32'(a_pc),     32'h20);
        check("ja_rd",    32'(a_rd),     32'h1);
        a_jump = 1'b0;
        step(2);
        check("ja_ins99", 32'(a_instr),  32'h99);
        check("ja_load",  32'(a_load),   32'h1);

        // Reset while presenting
        a_clb = 1'b1;
        step(1);
        check("mr_load",  32'(a_load),   32'h0);
        check("mr_instr", 32'(a_instr),  32'h00);
        check("mr_pc",    32'(a_pc),     32'h00);
        check("mr_halt",  32'(a_halted), 32'h0);
        a_clb = 1'b0; a_run = 1'b0;
        step(1);
        check("mr_idle",  32'(a_rd),     32'h0);

        // Wrap and longer latency on instance B
        mem_b[15] = 8'h3C;
        b_run = 1'b1; b_ready = 1'b1;
        step(1);
        check("b_rd",    32'(b_rd),    32'h1);
        check("b_addrF", 32'(b_addr),  32'hF);
        step(3);
        check("b_wait",  32'(b_load),  32'h0);
        step(1);
        check("b_load",  32'(b_load),  32'h1);
        check("b_ins",   32'(b_instr), 32'h3C);
        check("b_pcF",   32'(b_pc),    32'hF);
        b_run = 1'b0;
        step(1);
        check("b_wrap",  32'(b_pc),    32'h0);
        check("b_idle",  32'(b_load),  32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Producer side of the instruction-memory-to-instruction-register path.
- Holds the program counter and issues read requests to instruction memory.
- Waits out a fixed memory latency, captures the 8-bit instruction, then presents it to the instruction register with a load/ready handshake.
- Handles jumps by discarding in-flight fetches, and stops on a HALT opcode.

Parameters:
- ADDR_W, 8, program counter / instruction memory address width.
- MEM_LAT, 1, cycles from imem_rd assertion to imem_data valid; legal range 1..7.
- RESET_PC, 0, program counter value after reset.
- HALT_OPCODE, 4'hF, opcode in instr[7:4] that stops fetching.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- clb  in  1  reset: synchronous, active-high.
- run  in  1  level; permits new fetches.
- imem_addr  out  ADDR_W  read address to instruction memory.
- imem_rd  out  1  one-cycle read strobe.
- imem_data  in  8  instruction word from memory, valid MEM_LAT cycles after imem_rd.
- instr  out  8  captured instruction; [7:4] opcode, [3:0] register address/immediate.
- load_ir  out  1  instr valid; instruction register may load.
- ir_ready  in  1  instruction register accepts instr this cycle.
- jump  in  1  one-cycle redirect request.
- jump_target  in  ADDR_W  new PC when jump=1.
- pc  out  ADDR_W  current program counter.
- halted  out  1  high while in HALT.

Behaviour:
- Reset (clb=1 at posedge, overrides all else):
  - state=IDLE, pc=RESET_PC.
  - instr=0, load_ir=0, imem_rd=0, halted=0, wait counter=0.
  - Reset mid-fetch abandons the fetch; a late imem_data is ignored.
- State machine: IDLE, REQ, WAIT, PRESENT, HALT.
- IDLE:
  - All strobes low.
  - run=1 -> REQ.
- REQ (exactly 1 cycle):
  - imem_rd=1, imem_addr=pc.
  - Load wait counter with MEM_LAT-1.
  - -> WAIT.
- WAIT:
  - imem_rd=0; counter decrements each cycle.
  - In the cycle counter==0, capture imem_data into instr; -> PRESENT.
  - WAIT therefore lasts exactly MEM_LAT cycles.
- PRESENT:
  - load_ir=1; instr held stable until accepted.
  - Accept = load_ir & ir_ready. On accept, pc <= pc+1, wrapping modulo 2^ADDR_W (all-ones -> 0).
  - Then:
    - instr[7:4]==HALT_OPCODE -> HALT;
    - else run=1 -> REQ;
    - else -> IDLE.
  - ir_ready=0: stay in PRESENT (stall); pc unchanged.
- HALT:
  - halted=1, load_ir=0, no reads.
  - Exit only by reset or jump.
- jump=1 in any state (including HALT):
  - pc <= jump_target next cycle; state <= REQ.
  - load_ir drops next cycle; any captured or in-flight instruction is discarded.
  - halted clears.
- jump in the same cycle as an accept: the accept still completes (instr consumed), but pc=jump_target (jump wins over increment). HALT transition is suppressed.
- jump during WAIT: the pending imem_data is never captured.
- run deasserted: an in-flight fetch completes through PRESENT; no new REQ is issued.
- Timing (MEM_LAT=1, ir_ready tied 1): run rises before edge t; REQ at t, WAIT t+1, PRESENT t+2; next REQ t+3.
  - Throughput is one instruction per MEM_LAT+2 cycles.
- Output timing: all outputs are registered or decoded from state only; no combinational path from ir_ready to load_ir.

Decomposition:
- Shared package holds:
  - state enum (IDLE, REQ, WAIT, PRESENT, HALT);
  - HALT_OPCODE and the opcode field positions [7:4]/[3:0], shared with the instruction register and decoder;
  - ADDR_W default.
- One natural sub-module: fetch_pc_counter (PC register with reset value, increment-wrap, jump load; jump has priority over increment).

Test Plan:
- Straight-line fetch: MEM_LAT=1, memory[0..2]=8'h12,8'h34,8'h56, run=1, ir_ready=1 -> load_ir pulses at cycles 3,6,9 with instr 12,34,56; pc ends at 3.
- Stall: hold ir_ready=0 for 4 PRESENT cycles -> instr stays 8'h34, load_ir stays high, pc stays 1, no imem_rd pulses; release -> pc=2.
- Jump during WAIT: jump=1, jump_target=8'h40 while fetching addr 5 -> addr-5 data is never presented; next imem_addr=8'h40, pc=8'h41 after accept.
- Halt: memory[2]=8'hF0 -> accepted, pc=3, halted=1, no further imem_rd; jump to 8'h10 -> halted=0, fetch resumes at 8'h10.
- Wrap and latency: ADDR_W=4, MEM_LAT=3, start pc=4'hF -> imem_data captured 3 cycles after imem_rd; after accept pc=0.
- Reset mid-operation: clb=1 during PRESENT -> next cycle load_ir=0, instr=0, pc=RESET_PC, state IDLE.
